pipeline_fetch: RTL
===================

Name: pipeline_fetch

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the LEGv8 pipelined core; sits directly upstream of decode inside PipelineTOP.
- Holds the PC and drives the instruction-memory address. Registers {pc, inst, valid} into IF/ID.
- Honours stall from the hazard unit and redirect/flush from the branch-resolution stage.
- Stops fetching on a halt encoding or when the PC runs off the end of instruction memory.

Parameters:
- PC_W, 64, PC / address width (`WORD).
- INST_W, 32, instruction width (`INST_SIZE).
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_DEPTH, 256, instruction memory depth in words; fetch limit = IMEM_DEPTH*4 bytes.
- HALT_INST, 32'hD4400000, encoding that stops fetch (LEGv8 HLT #0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  PC_W  byte address to instruction memory; combinational from the PC register.
- imem_rdata  in  INST_W  instruction at imem_addr; combinational read, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  taken branch or jump resolved; flush IF/ID.
- redirect_pc  in  PC_W  target of the redirect.
- id_pc  out  PC_W  IF/ID register: PC of id_inst.
- id_inst  out  INST_W  IF/ID register: instruction.
- id_valid  out  1  IF/ID register: id_inst is real (0 = bubble).
- halted  out  1  fetch stopped.
- fetch_count  out  32  number of instructions delivered to IF/ID (saturating).

Behaviour:
- Reset (async, rst_n=0) sets: pc=RESET_PC, id_pc=0, id_inst=0, id_valid=0, halted=0, fetch_count=0, state=BOOT.
- States:
  - BOOT: one-cycle bubble after reset release. id_valid=0, PC unchanged. Next state RUN.
  - RUN: normal fetch.
  - HALT: pc frozen, id_valid=0 every cycle, halted=1. Only reset leaves HALT; redirect and stall are ignored.
- RUN, per rising edge, in priority order:
  1. redirect=1: pc<=redirect_pc with bits [1:0] forced to 0; id_valid<=0; id_inst<=0. Overrides stall in the same cycle. fetch_count unchanged.
  2. stall=1: pc, id_pc, id_inst, id_valid all hold. fetch_count unchanged.
  3. Otherwise: id_pc<=pc; id_inst<=imem_rdata; id_valid<=1; pc<=pc+4; fetch_count<=fetch_count+1 (saturates at 32'hFFFFFFFF).
- Halt detection, evaluated only in case 3:
  - imem_rdata==HALT_INST: the halt instruction is not delivered (id_valid<=0), pc holds, state<=HALT.
  - pc >= IMEM_DEPTH*4: same action; imem_rdata is ignored.
- halted is registered: it goes to 1 on the edge that enters HALT.
- Latency: the instruction at address A reaches id_inst one edge after pc==A, provided no stall or redirect.
- PC arithmetic is modulo 2^PC_W; wrap-around is unreachable in practice because the limit check fires first.
- A redirect arriving during BOOT is taken: pc<=target and state<=RUN.
- imem_addr always equals the pc register, including during stall and HALT.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous), regardless of state.

Test Plan:
- Reset/boot: rst_n low for 1 cycle, imem holds 0xf8400009 at address 0 -> id_valid=0 in the BOOT cycle. Next edge: id_inst=0xf8400009, id_pc=0, id_valid=1, pc=4, fetch_count=1.
- Stall: stall=1 for 2 cycles while id_inst=0x8B0A0149 and pc=8 -> id_inst, id_pc=4, pc=8 all held, fetch_count unchanged. Resumes with the instruction at address 8 on the next free edge.
- Redirect priority: stall=1 and redirect=1 together with redirect_pc=0x43 -> pc=0x40, id_valid=0, id_inst=0. Next edge: id_pc=0x40.
- Halt encoding: instruction 0xD4400000 at address 0x14 -> not delivered, halted=1, pc stays 0x14, id_valid=0 forever. A later redirect=1 has no effect.
- Memory limit: IMEM_DEPTH=4 with no halt instruction -> after 4 deliveries pc=0x10, halted=1, fetch_count=4.
- Async reset mid-run: rst_n driven low between clock edges at pc=0x20 -> pc=0, id_valid=0, fetch_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, hazard/branch controls
// and the IF/ID register outputs. master = fetch stage, slave = environment.
interface pipeline_fetch_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic              halted;
  logic [31:0]       fetch_count;

  modport master (
    output imem_addr, id_pc, id_inst, id_valid,
    output halted, fetch_count,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, id_pc, id_inst, id_valid,
    input  halted, fetch_count,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/pipeline_fetch.sv
// LEGv8 instruction fetch + IF/ID register with stall, redirect and halt.
// Ports: clk, rst_n (async low), bus (pipeline_fetch_if.master).
module pipeline_fetch #(
  parameter int                PC_W       = 64,
  parameter int                INST_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter int                IMEM_DEPTH = 256,
  parameter logic [INST_W-1:0] HALT_INST  = 32'hD440_0000
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_fetch_if.master bus
);

  localparam logic [PC_W-1:0] LIMIT = PC_W'(IMEM_DEPTH) << 2;
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              halted_q, halted_d;
  logic [31:0]       cnt_q, cnt_d;

  logic stop_fetch;
  assign stop_fetch = (bus.imem_rdata == HALT_INST)
                    || (pc_q >= LIMIT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      BOOT: begin
        state_d    = RUN;
        id_valid_d = 1'b0;
        if (bus.redirect) pc_d = bus.redirect_pc & ALIGN;
      end
      RUN: begin
        if (bus.redirect) begin
          pc_d       = bus.redirect_pc & ALIGN;
          id_valid_d = 1'b0;
          id_inst_d  = '0;
        end else if (bus.stall) begin
          // everything holds
        end else if (stop_fetch) begin
          // halt word is swallowed; PC stays on it
          id_valid_d = 1'b0;
          halted_d   = 1'b1;
          state_d    = HALT;
        end else begin
          id_pc_d    = pc_q;
          id_inst_d  = bus.imem_rdata;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PC_W'(4);
          if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = cnt_q;

endmodule
